// File: rtl/bxu_exec_if.sv
// bxu_exec_if: memory, decoder and byte-stream signals around the BXU execution sequencer.
interface bxu_exec_if #(
  parameter int unsigned DATA_BITWIDTH  = 8,
  parameter int unsigned CODE_BITWIDTH  = 16,
  parameter int unsigned CADDR_BITWIDTH = 10,
  parameter int unsigned DADDR_BITWIDTH = 10
);
  logic [CADDR_BITWIDTH-1:0] code_addr;
  logic                      code_rd;
  logic [CODE_BITWIDTH-1:0]  code_rdata;
  logic [DADDR_BITWIDTH-1:0] data_addr;
  logic                      data_rd;
  logic [DATA_BITWIDTH-1:0]  data_rdata;
  logic                      data_we;
  logic [DATA_BITWIDTH-1:0]  data_wdata;
  logic [CODE_BITWIDTH-1:0]  code;
  logic [DATA_BITWIDTH-1:0]  data;
  logic                      data_wr;
  logic                      io_input_ready;
  logic                      io_input_done;
  logic                      io_output_ready;
  logic                      io_output_done;
  logic [1:0]                flag_op_caddr;
  logic [1:0]                flag_op_daddr;
  logic [1:0]                flag_op_data;
  logic                      flag_op_data_wr;
  logic                      flag_op_input_done;
  logic                      flag_op_output_ready;
  logic                      in_valid;
  logic [DATA_BITWIDTH-1:0]  in_data;
  logic                      in_ack;
  logic                      out_valid;
  logic [DATA_BITWIDTH-1:0]  out_data;
  logic                      out_ack;

  // Sequencer side
  modport master (
    output code_addr, code_rd, data_addr, data_rd, data_we, data_wdata,
    output code, data, data_wr,
    output io_input_ready, io_input_done, io_output_ready, io_output_done,
    output in_ack, out_valid, out_data,
    input  code_rdata, data_rdata,
    input  flag_op_caddr, flag_op_daddr, flag_op_data, flag_op_data_wr,
    input  flag_op_input_done, flag_op_output_ready,
    input  in_valid, in_data, out_ack
  );

  // Memories, decoder and stream endpoints
  modport slave (
    input  code_addr, code_rd, data_addr, data_rd, data_we, data_wdata,
    input  code, data, data_wr,
    input  io_input_ready, io_input_done, io_output_ready, io_output_done,
    input  in_ack, out_valid, out_data,
    output code_rdata, data_rdata,
    output flag_op_caddr, flag_op_daddr, flag_op_data, flag_op_data_wr,
    output flag_op_input_done, flag_op_output_ready,
    output in_valid, in_data, out_ack
  );
endinterface

// File: rtl/bxu_exec.sv
// bxu_exec: fetch/load/decode/exec/writeback sequencer for the BXU core, with
// the byte-stream input/output handshakes. Optional retired-instruction
// counter is enabled by defining BXU_EXEC_PERF_EN.
module bxu_exec #(
  parameter int unsigned DATA_BITWIDTH  = 8,
  parameter int unsigned CODE_BITWIDTH  = 16,
  parameter int unsigned CADDR_BITWIDTH = 10,
  parameter int unsigned DADDR_BITWIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        busy,
  output logic [31:0] perf_retired,
  bxu_exec_if.master  bus
);
  localparam int unsigned OPND_BITWIDTH = CODE_BITWIDTH - 4;

  localparam logic [1:0] CADDR_NOP = 2'd0;
  localparam logic [1:0] CADDR_INC = 2'd1;
  localparam logic [1:0] CADDR_MOD = 2'd2;
  localparam logic [1:0] CADDR_SET = 2'd3;
  localparam logic [1:0] DADDR_MOD = 2'd1;
  localparam logic [1:0] DADDR_SET = 2'd2;
  localparam logic [1:0] DATA_MOD  = 2'd1;
  localparam logic [1:0] DATA_SET  = 2'd2;
  localparam logic [1:0] DATA_GET  = 2'd3;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, DECODE, EXEC, WB} state_t;

  state_t                    state, state_n;
  logic [CADDR_BITWIDTH-1:0] caddr, caddr_n;
  logic [DADDR_BITWIDTH-1:0] daddr, daddr_n;
  logic [CODE_BITWIDTH-1:0]  code_q, code_q_n, code_r;
  logic [DATA_BITWIDTH-1:0]  data_q, data_q_n, data_new;
  logic [DATA_BITWIDTH-1:0]  in_q, in_q_n, out_q, out_q_n;
  logic [OPND_BITWIDTH-1:0]  opnd;
  logic in_ready, in_ready_n, in_done, in_done_n;
  logic out_ready, out_ready_n, out_done, out_done_n;
  logic code_rd_r, data_rd_r, wb_r, in_ack_r, out_valid_r;

  assign opnd = code_q[CODE_BITWIDTH-1:4];

  // Next state, address/data-cell updates and handshake next values
  always_comb begin
    state_n  = state;
    caddr_n  = caddr;
    daddr_n  = daddr;
    code_q_n = code_q;
    data_q_n = data_q;
    data_new = data_q;

    case (bus.flag_op_data)
      DATA_MOD: data_new = data_q + DATA_BITWIDTH'(opnd);
      DATA_SET: data_new = DATA_BITWIDTH'(opnd);
      DATA_GET: data_new = in_q;
      default:  data_new = data_q;
    endcase

    case (state)
      IDLE:    if (run) state_n = FETCH;
      FETCH:   state_n = LOAD;
      LOAD: begin
        code_q_n = bus.code_rdata;
        state_n  = DECODE;
      end
      DECODE: begin
        data_q_n = bus.data_rdata;
        state_n  = EXEC;
      end
      EXEC: begin
        if (bus.flag_op_caddr != CADDR_NOP) begin
          case (bus.flag_op_caddr)
            CADDR_INC: caddr_n = caddr + CADDR_BITWIDTH'(1);
            CADDR_MOD: caddr_n = caddr + CADDR_BITWIDTH'($signed(opnd));
            CADDR_SET: caddr_n = CADDR_BITWIDTH'(opnd);
            default:   caddr_n = caddr;
          endcase
          case (bus.flag_op_daddr)
            DADDR_MOD: daddr_n = daddr + DADDR_BITWIDTH'($signed(opnd));
            DADDR_SET: daddr_n = DADDR_BITWIDTH'(opnd);
            default:   daddr_n = daddr;
          endcase
          if (bus.flag_op_data_wr) begin
            data_q_n = data_new;
            state_n  = WB;
          end else begin
            state_n = run ? FETCH : IDLE;
          end
        end
      end
      WB:      state_n = run ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase

    // Input: ack clear has priority over capturing a new byte
    in_ready_n = in_ready;
    in_q_n     = in_q;
    in_done_n  = bus.flag_op_input_done;
    if (in_ready && in_done) begin
      in_ready_n = 1'b0;
    end else if (bus.in_valid && !in_ready && !in_done) begin
      in_ready_n = 1'b1;
      in_q_n     = bus.in_data;
    end

    // Output: latch the byte as ready rises; done holds until ready drops
    out_ready_n = bus.flag_op_output_ready;
    out_q_n     = (out_ready_n && !out_ready) ? data_q : out_q;
    out_done_n  = out_ready ? (out_done || (bus.out_ack && out_valid_r)) : 1'b0;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      caddr       <= '0;
      daddr       <= '0;
      code_q      <= '0;
      data_q      <= '0;
      in_q        <= '0;
      out_q       <= '0;
      in_ready    <= 1'b0;
      in_done     <= 1'b0;
      out_ready   <= 1'b0;
      out_done    <= 1'b0;
      busy        <= 1'b0;
      code_r      <= '0;
      code_rd_r   <= 1'b0;
      data_rd_r   <= 1'b0;
      wb_r        <= 1'b0;
      in_ack_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state       <= state_n;
      caddr       <= caddr_n;
      daddr       <= daddr_n;
      code_q      <= code_q_n;
      data_q      <= data_q_n;
      in_q        <= in_q_n;
      out_q       <= out_q_n;
      in_ready    <= in_ready_n;
      in_done     <= in_done_n;
      out_ready   <= out_ready_n;
      out_done    <= out_done_n;
      busy        <= (state_n != IDLE);
      code_r      <= (state_n == EXEC) ? code_q_n : '0;
      code_rd_r   <= (state_n == FETCH);
      data_rd_r   <= (state_n == LOAD);
      wb_r        <= (state_n == WB);
      in_ack_r    <= in_ready_n && in_done_n;
      out_valid_r <= out_ready_n && !out_done_n;
    end
  end

  assign bus.code_addr       = caddr;
  assign bus.code_rd         = code_rd_r;
  assign bus.data_addr       = daddr;
  assign bus.data_rd         = data_rd_r;
  assign bus.data_we         = wb_r;
  assign bus.data_wdata      = data_q;
  assign bus.code            = code_r;
  assign bus.data            = data_q;
  assign bus.data_wr         = wb_r;
  assign bus.io_input_ready  = in_ready;
  assign bus.io_input_done   = in_done;
  assign bus.io_output_ready = out_ready;
  assign bus.io_output_done  = out_done;
  assign bus.in_ack          = in_ack_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_data        = out_q;

`ifdef BXU_EXEC_PERF_EN
  logic        retire;
  logic [31:0] perf_cnt;

  assign retire = (state == EXEC) && (bus.flag_op_caddr != CADDR_NOP);

  // Retired-instruction counter, wraps at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt <= '0;
    else if (retire) perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_retired = perf_cnt;
`else
  assign perf_retired = 32'd0;
`endif
endmodule

// File: tb/tb_bxu_exec.sv
// tb_bxu_exec: directed bench for bxu_exec with code/data memory models and a
// small front decoder (op 1 jmp mod, 2 data mod, 3 data set, 4 daddr mod,
// 5 input, 6 output + daddr mod, 7 jmp set).
module tb_bxu_exec;
`ifdef BXU_EXEC_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd7;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        busy;
  logic [31:0] perf_retired;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;
  logic [7:0] last_wdata = 8'h00;

  logic [15:0] code_mem [1024];
  logic [7:0]  data_mem [1024];

  bxu_exec_if bus ();

  bxu_exec dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .busy         (busy),
    .perf_retired (perf_retired),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Memories and write / ack monitor
  always @(posedge clk) begin
    if (bus.code_rd) bus.code_rdata <= code_mem[bus.code_addr];
    if (bus.data_rd) bus.data_rdata <= data_mem[bus.data_addr];
    if (bus.data_we) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= bus.data_wdata;
    end
    if (bus.in_ack) ack_cnt <= ack_cnt + 1;
  end

  // Front decoder model
  always_comb begin
    bus.flag_op_caddr        = 2'd0;
    bus.flag_op_daddr        = 2'd0;
    bus.flag_op_data         = 2'd0;
    bus.flag_op_data_wr      = 1'b0;
    bus.flag_op_input_done   = 1'b0;
    bus.flag_op_output_ready = 1'b0;
    case (bus.code[3:0])
      4'h1: bus.flag_op_caddr = 2'd2;
      4'h2: begin bus.flag_op_caddr = 2'd1; bus.flag_op_data = 2'd1; bus.flag_op_data_wr = 1'b1; end
      4'h3: begin bus.flag_op_caddr = 2'd1; bus.flag_op_data = 2'd2; bus.flag_op_data_wr = 1'b1; end
      4'h4: begin bus.flag_op_caddr = 2'd1; bus.flag_op_daddr = 2'd1; end
      4'h5: if (bus.io_input_ready && !bus.io_input_done) begin
        bus.flag_op_caddr      = 2'd1;
        bus.flag_op_data       = 2'd3;
        bus.flag_op_data_wr    = 1'b1;
        bus.flag_op_input_done = 1'b1;
      end
      4'h6: if (!bus.io_output_ready && !bus.io_output_done) begin
        bus.flag_op_caddr        = 2'd1;
        bus.flag_op_daddr        = 2'd1;
        bus.flag_op_output_ready = 1'b1;
      end
      4'h7: bus.flag_op_caddr = 2'd3;
      default: ;
    endcase
    if (bus.io_input_done && bus.io_input_ready) bus.flag_op_input_done = 1'b1;
    if (bus.io_output_ready && !bus.io_output_done) bus.flag_op_output_ready = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    run          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.out_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      code_mem[i] = 16'h0000;
      data_mem[i] = 8'h00;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (bus.code_addr !== 10'h000) begin failures++; $display("FAIL reset_caddr got=%0h exp=0", bus.code_addr); end
    checks++; if (bus.data_addr !== 10'h000) begin failures++; $display("FAIL reset_daddr got=%0h exp=0", bus.data_addr); end
    checks++; if (bus.code !== 16'h0000) begin failures++; $display("FAIL reset_code got=%0h exp=0", bus.code); end
    checks++; if (bus.data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.data); end
    checks++; if ({bus.code_rd, bus.data_rd, bus.data_we, bus.data_wr} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {bus.code_rd, bus.data_rd, bus.data_we, bus.data_wr}); end
    checks++; if ({bus.io_input_ready, bus.io_input_done, bus.io_output_ready, bus.io_output_done} !== 4'b0000) begin
      failures++; $display("FAIL reset_io got=%b exp=0000", {bus.io_input_ready, bus.io_input_done, bus.io_output_ready, bus.io_output_done}); end
    checks++; if ({bus.in_ack, bus.out_valid} !== 2'b00) begin failures++; $display("FAIL reset_ack_valid got=%b exp=00", {bus.in_ack, bus.out_valid}); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    checks++; if (perf_retired !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d exp=0", perf_retired); end
  endtask

  task automatic test_data_mod();
    int w0;
    clear_mem();
    code_mem[0] = 16'h0012;
    data_mem[0] = 8'h05;
    do_reset();
    w0  = wr_cnt;
    run = 1'b1;
    tick();
    checks++; if (bus.code_rd !== 1'b1) begin failures++; $display("FAIL dmod_code_rd got=%0h exp=1", bus.code_rd); end
    tick();
    checks++; if (bus.data_rd !== 1'b1) begin failures++; $display("FAIL dmod_data_rd got=%0h exp=1", bus.data_rd); end
    tick();
    tick();
    checks++; if (bus.code !== 16'h0012) begin failures++; $display("FAIL dmod_exec_code got=%0h exp=12", bus.code); end
    checks++; if (bus.data !== 8'h05) begin failures++; $display("FAIL dmod_exec_data got=%0h exp=5", bus.data); end
    checks++; if (bus.data_we !== 1'b0) begin failures++; $display("FAIL dmod_early_we got=%0h exp=0", bus.data_we); end
    tick();
    checks++; if (bus.data_we !== 1'b1 || bus.data_wdata !== 8'h06) begin
      failures++; $display("FAIL dmod_wb got_we=%0h got_wdata=%0h exp_we=1 exp_wdata=06", bus.data_we, bus.data_wdata); end
    checks++; if (bus.code_addr !== 10'h001) begin failures++; $display("FAIL dmod_caddr got=%0h exp=1", bus.code_addr); end
    run = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dmod_idle got=%0h exp=0", busy); end
    checks++; if (wr_cnt - w0 !== 1 || last_wdata !== 8'h06) begin
      failures++; $display("FAIL dmod_writes got_cnt=%0d got_val=%0h exp_cnt=1 exp_val=06", wr_cnt - w0, last_wdata); end
  endtask

  task automatic test_jump_wrap();
    clear_mem();
    code_mem[0] = 16'hFFF1;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (3) tick();
    checks++; if (bus.code !== 16'hFFF1) begin failures++; $display("FAIL jmp_exec_code got=%0h exp=fff1", bus.code); end
    tick();
    checks++; if (bus.code_addr !== 10'h3FF) begin failures++; $display("FAIL jmp_wrap_caddr got=%0h exp=3ff", bus.code_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL jmp_idle got=%0h exp=0", busy); end
    checks++; if (bus.code !== 16'h0000) begin failures++; $display("FAIL jmp_code_cleared got=%0h exp=0", bus.code); end
  endtask

  task automatic test_input_stall();
    int a0;
    int w0;
    logic stall_bad;
    clear_mem();
    code_mem[0] = 16'h0005;
    do_reset();
    a0 = ack_cnt;
    w0 = wr_cnt;
    stall_bad = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.code_addr !== 10'h000 || busy !== 1'b1 || bus.data_we !== 1'b0) stall_bad = 1'b1;
    end
    checks++; if (stall_bad !== 1'b0) begin failures++; $display("FAIL in_stall_hold got=%0h exp=0", stall_bad); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.io_input_ready !== 1'b1) begin failures++; $display("FAIL in_ready_set got=%0h exp=1", bus.io_input_ready); end
    tick();
    checks++; if (bus.data_we !== 1'b1 || bus.data_wdata !== 8'hA5) begin
      failures++; $display("FAIL in_wb got_we=%0h got_wdata=%0h exp_we=1 exp_wdata=a5", bus.data_we, bus.data_wdata); end
    checks++; if (bus.in_ack !== 1'b1) begin failures++; $display("FAIL in_ack_pulse got=%0h exp=1", bus.in_ack); end
    repeat (4) tick();
    checks++; if (ack_cnt - a0 !== 1) begin failures++; $display("FAIL in_ack_count got=%0d exp=1", ack_cnt - a0); end
    checks++; if (wr_cnt - w0 !== 1 || last_wdata !== 8'hA5) begin
      failures++; $display("FAIL in_writes got_cnt=%0d got_val=%0h exp_cnt=1 exp_val=a5", wr_cnt - w0, last_wdata); end
    checks++; if (bus.code_addr !== 10'h001) begin failures++; $display("FAIL in_caddr got=%0h exp=1", bus.code_addr); end
    checks++; if ({bus.io_input_ready, bus.io_input_done} !== 2'b00) begin
      failures++; $display("FAIL in_io_clear got=%b exp=00", {bus.io_input_ready, bus.io_input_done}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL in_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int nbytes;
    int vcnt;
    int ack_cyc;
    int ret_cyc;
    logic [7:0] got0;
    logic [7:0] got1;
    logic done_wait;
    clear_mem();
    code_mem[0] = 16'h0016;
    code_mem[1] = 16'h0006;
    code_mem[2] = 16'h0027;
    data_mem[0] = 8'h11;
    data_mem[1] = 8'h22;
    do_reset();
    nbytes = 0; vcnt = 0; ack_cyc = -1; ret_cyc = -1;
    got0 = 8'h00; got1 = 8'h00;
    run = 1'b1;
    for (int cyc = 0; cyc < 300 && nbytes < 2; cyc++) begin
      tick();
      bus.out_ack = 1'b0;
      if (bus.code_addr == 10'h002 && ret_cyc < 0) ret_cyc = cyc;
      if (bus.out_valid) begin
        vcnt++;
        if (vcnt == 4) begin
          bus.out_ack = 1'b1;
          if (nbytes == 0) begin got0 = bus.out_data; ack_cyc = cyc; end
          else got1 = bus.out_data;
          nbytes++;
          vcnt = 0;
        end
      end
    end
    run = 1'b0;
    done_wait = 1'b0;
    for (int cyc = 0; cyc < 50 && !done_wait; cyc++) begin
      tick();
      bus.out_ack = 1'b0;
      if (busy == 1'b0) done_wait = 1'b1;
    end
    checks++; if (nbytes !== 2) begin failures++; $display("FAIL b2b_bytes got=%0d exp=2", nbytes); end
    checks++; if (got0 !== 8'h11) begin failures++; $display("FAIL b2b_byte0 got=%0h exp=11", got0); end
    checks++; if (got1 !== 8'h22) begin failures++; $display("FAIL b2b_byte1 got=%0h exp=22", got1); end
    checks++; if (ret_cyc - ack_cyc !== 4) begin
      failures++; $display("FAIL b2b_stall got_gap=%0d exp_gap=4 (ack=%0d ret=%0d)", ret_cyc - ack_cyc, ack_cyc, ret_cyc); end
    checks++; if (done_wait !== 1'b1) begin failures++; $display("FAIL b2b_idle_timeout got=%0h exp=1", done_wait); end
  endtask

  task automatic test_reset_in_wb();
    int w0;
    clear_mem();
    code_mem[0] = 16'h0012;
    data_mem[0] = 8'h05;
    do_reset();
    run = 1'b1;
    repeat (5) tick();
    checks++; if (bus.data_we !== 1'b1) begin failures++; $display("FAIL rwb_in_wb got=%0h exp=1", bus.data_we); end
    w0 = wr_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.data_we !== 1'b0) begin failures++; $display("FAIL rwb_we got=%0h exp=0", bus.data_we); end
    checks++; if (busy !== 1'b0 || bus.code_addr !== 10'h000 || bus.data !== 8'h00) begin
      failures++; $display("FAIL rwb_state got_busy=%0h got_caddr=%0h got_data=%0h exp=0", busy, bus.code_addr, bus.data); end
    tick();
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL rwb_no_write got=%0d exp=%0d", wr_cnt, w0); end
    do_reset();
  endtask

  task automatic test_perf();
    logic done_wait;
    clear_mem();
    for (int i = 0; i < 8; i++) code_mem[i] = 16'h0014;
    do_reset();
    done_wait = 1'b0;
    run = 1'b1;
    for (int cyc = 0; cyc < 200 && !done_wait; cyc++) begin
      tick();
      if (run && bus.code_addr == 10'h006) run = 1'b0;
      if (!run && busy == 1'b0) done_wait = 1'b1;
    end
    checks++; if (done_wait !== 1'b1) begin failures++; $display("FAIL perf_timeout got=%0h exp=1", done_wait); end
    checks++; if (bus.code_addr !== 10'h007 || bus.data_addr !== 10'h007) begin
      failures++; $display("FAIL perf_addrs got_caddr=%0h got_daddr=%0h exp=7", bus.code_addr, bus.data_addr); end
    checks++; if (perf_retired !== PERF_EXP) begin failures++; $display("FAIL perf_count got=%0d exp=%0d", perf_retired, PERF_EXP); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.out_ack  = 1'b0;
    clear_mem();
    test_reset();
    test_data_mod();
    test_jump_wrap();
    test_input_stall();
    test_back_to_back();
    test_reset_in_wb();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bxu_exec.md
# bxu_exec

Execution sequencer for the BXU core. It fetches code words and loads the data cell, then presents the current instruction to the front decoder. It applies the decoder's caddr/daddr/data/io flags to the code-address, data-address and data-cell registers, and runs the input/output handshakes. It sits between the code and data memories, the front decoder and the external byte-stream ports.

## Interface
- DATA_BITWIDTH, 8, data cell / io byte width
- CODE_BITWIDTH, 16, code word width; op = code[3:0], operand = code[15:4]
- CADDR_BITWIDTH, 10, code address width
- DADDR_BITWIDTH, 10, data address width
- CADDR_NOP/INC/MOD/SET, 0/1/2/3, caddr flag encodings
- DADDR_NOP/MOD/SET, 0/1/2, daddr flag encodings
- DATA_NOP/MOD/SET/GET, 0/1/2/3, data flag encodings

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; high = execute, low = stop at the next instruction boundary
- busy  out  1  state != IDLE
- code_addr  out  CADDR_BITWIDTH  code memory address (= caddr)
- code_rd  out  1  code read strobe; code_rdata is valid the next cycle
- code_rdata  in  CODE_BITWIDTH  code memory read data
- data_addr  out  DADDR_BITWIDTH  data memory address (= daddr)
- data_rd  out  1  data read strobe; data_rdata is valid the next cycle
- data_rdata  in  DATA_BITWIDTH  data memory read data
- data_we  out  1  data write strobe
- data_wdata  out  DATA_BITWIDTH  data write value
- code  out  CODE_BITWIDTH  to decoder; code_q in EXEC, else 0 (nop)
- data  out  DATA_BITWIDTH  to decoder; data_q
- data_wr  out  1  to decoder; high in WB
- io_input_ready, io_input_done, io_output_ready, io_output_done  out  1 each  handshake registers, also fed to the decoder
- flag_op_caddr  in  2  decoder caddr flag
- flag_op_daddr  in  2  decoder daddr flag
- flag_op_data  in  2  decoder data flag
- flag_op_data_wr  in  1  decoder data write flag
- flag_op_input_done  in  1  decoder input-done flag
- flag_op_output_ready  in  1  decoder output-ready flag
- in_valid  in  1  external byte offered
- in_data  in  DATA_BITWIDTH  external input byte
- in_ack  out  1  one-cycle pulse when the byte has been consumed
- out_valid  out  1  output byte offered
- out_data  out  DATA_BITWIDTH  output byte
- out_ack  in  1  external sink accepted the byte
- perf_retired  out  32  retired-instruction count (see Configuration)

## Operation
- States: IDLE, FETCH, LOAD, DECODE, EXEC, WB.
- IDLE: leaves for FETCH when run=1.
- FETCH: code_rd=1.
- LOAD: code_q<=code_rdata; data_rd=1.
- DECODE: data_q<=data_rdata.
- EXEC: the decoder sees code_q and data_q. The flags are applied on the clock edge:
  - flag_op_caddr=CADDR_NOP: stall and stay in EXEC; the flags are re-evaluated each cycle.
  - Otherwise: update caddr and daddr. If flag_op_data_wr=1, data_q<= the new value and go to WB. Else go to FETCH, or to IDLE if run=0.
- WB: data_we=1 with data_wdata=data_q. Then go to FETCH, or to IDLE if run=0.
- Code address: INC = caddr+1; MOD = caddr+sext(operand); SET = operand. The result is truncated to CADDR_BITWIDTH and wraps modulo 2^CADDR_BITWIDTH.
- Data address: MOD and SET follow the same rules at DADDR_BITWIDTH.
- Data cell: MOD = data_q+operand[DATA_BITWIDTH-1:0] mod 2^DATA_BITWIDTH; SET = operand[DATA_BITWIDTH-1:0]; GET = in_q.
- Input handshake:
  - io_input_ready sets when in_valid & ~io_input_ready & ~io_input_done; in_q<=in_data on the same edge.
  - io_input_done<=flag_op_input_done every cycle.
  - in_ack = io_input_ready & io_input_done. io_input_ready clears on the in_ack edge; io_input_done then falls the following cycle.
- Output handshake:
  - io_output_ready<=flag_op_output_ready every cycle.
  - On the edge where io_output_ready rises, out_q<=data_q.
  - io_output_done sets on out_ack & out_valid and clears when io_output_ready=0.
  - out_valid = io_output_ready & ~io_output_done; out_data = out_q.
- Because code=0 outside EXEC, the decoder produces only the handshake hold terms there.

## Timing
- Reset: state IDLE; caddr, daddr, code_q, data_q, in_q, out_q = 0; all io registers, strobes, in_ack, out_valid and perf_retired = 0.
- Reset asserted mid-instruction aborts immediately; no write completes.
- Instruction latency: 4 cycles without write, 5 with write, plus EXEC stall cycles.
- Input op with io_input_ready=0 stalls until a byte arrives. A second input op needs io_input_done=0 again.
- Output op with a byte in flight stalls until out_ack, io_output_ready clearing and io_output_done clearing (at least 3 cycles after out_ack).
- in_valid and the in_ack clear arriving on the same edge: the clear wins; the new byte is captured after io_input_done falls.
- run dropping during a stall: the stall completes, then the block goes to IDLE.

## Configuration
- BXU_EXEC_PERF_EN defined: perf_retired increments on each EXEC exit (non-stall) and wraps at 2^32.
- Not defined: perf_retired is tied to 0 and no counter logic is present.

## Test plan
- Code 0x0012 (data mod +1) at caddr 0, data[0]=0x05, run=1 -> data_we with data_wdata=0x06 at cycle 5; caddr=1.
- Code 0xFFF1 (jump mod -1) at caddr 0 -> caddr wraps to 0x3FF.
- Input op with in_valid low for 10 cycles, then in_valid with in_data=0xA5 -> caddr held during the stall; data written 0xA5; one in_ack pulse.
- Two back-to-back output ops with out_ack delayed 4 cycles -> the second op stalls until the first handshake finishes; out_data matches each data_q.
- Reset asserted in WB -> no data_we; all outputs 0 next cycle.
- With BXU_EXEC_PERF_EN, run 7 instructions -> perf_retired=7; without the macro, perf_retired=0.
